rle_encoder: RTL and testbench



---
 rtl/rle_pkg.sv | 16 +
 rtl/rle_out_slot.sv | 51 +++++
 rtl/rle_encoder.sv | 106 ++++++++++
 tb/tb_rle_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// rle_pkg: shared state type, word geometry and count-word builder for the run-length encoder
package rle_pkg;

    localparam int RLE_DW       = 32;
    localparam int RLE_MARK_BIT = RLE_DW - 1;

    typedef enum logic {IDLE, RUN} rle_state_e;

    function automatic logic [RLE_DW-1:0] count_word(input logic [RLE_DW-2:0] cnt);
        logic [RLE_DW-1:0] w;
        w               = {1'b0, cnt};
        w[RLE_MARK_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/rle_out_slot.sv
// rle_out_slot: output register with a one-deep pending word queued behind it
module rle_out_slot
    import rle_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              out_ready,
    input  logic              load_out,
    input  logic [RLE_DW-1:0] out_word,
    input  logic              load_pend,
    input  logic [RLE_DW-1:0] pend_word,
    output logic [RLE_DW-1:0] out_data,
    output logic              out_valid,
    output logic              pend_valid,
    output logic              slot_free
);

    logic [RLE_DW-1:0] out_q, out_d, pend_q, pend_d;
    logic              out_valid_q, out_valid_d, pend_valid_q, pend_valid_d;
    logic              pend_move;

    assign slot_free  = !out_valid_q || out_ready;
    assign pend_move  = slot_free && pend_valid_q;
    assign out_data   = out_q;
    assign out_valid  = out_valid_q;
    assign pend_valid = pend_valid_q;

    // The pending word owns the free slot first; the encoder only loads when nothing is pending
    always_comb begin
        out_d        = pend_move ? pend_q : load_out ? out_word : out_q;
        out_valid_d  = pend_move || load_out || (out_valid_q && !out_ready);
        pend_d       = load_pend ? pend_word : pend_q;
        pend_valid_d = load_pend || (pend_valid_q && !slot_free);
    end

    // Output and pending registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: rtl/rle_encoder.sv
// rle_encoder: run-length compresses the capture sample stream into value and marker-tagged count words
module rle_encoder
    import rle_pkg::*;
#(
    parameter int CW = RLE_DW - 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rle_en,
    input  logic [RLE_DW-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [RLE_DW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int            DW       = RLE_DW;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CNT_MAX - CW'(1);

    rle_state_e    state_q, state_d;
    logic          mode_q, mode_d, flush_pend_q, flush_pend_d;
    logic [DW-2:0] last_q, last_d;
    logic [CW-1:0] count_q, count_d;
    logic          pend_valid, slot_free, accept, service, same;
    logic          load_out, load_pend;
    logic [DW-1:0] out_word, masked;

    assign in_ready = !pend_valid && !flush_pend_q && slot_free;
    assign accept   = in_valid && in_ready;
    assign service  = flush_pend_q && !pend_valid && slot_free;
    assign masked   = {1'b0, in_data[DW-2:0]};
    assign same     = in_data[DW-2:0] == last_q;

    // Flush service and sample acceptance never coincide: a pending flush holds in_ready low
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        last_d       = last_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q || flush;
        load_out     = 1'b0;
        load_pend    = 1'b0;
        out_word     = masked;
        if (service) begin
            load_out     = state_q == RUN && mode_q && count_q != '0;
            out_word     = count_word((DW-1)'(count_q));
            count_d      = '0;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
        end else if (accept) begin
            if (state_q == IDLE) begin
                mode_d   = rle_en;
                load_out = 1'b1;
                out_word = rle_en ? masked : in_data;
                last_d   = in_data[DW-2:0];
                count_d  = '0;
                state_d  = rle_en ? RUN : IDLE;
            end else if (same) begin
                load_out = count_q == CNT_LAST;
                out_word = count_word((DW-1)'(CNT_MAX));
                count_d  = count_q == CNT_LAST ? '0 : count_q + CW'(1);
            end else begin
                load_out  = 1'b1;
                load_pend = count_q != '0;
                out_word  = count_q != '0 ? count_word((DW-1)'(count_q)) : masked;
                last_d    = in_data[DW-2:0];
                count_d   = '0;
            end
        end
    end

    // Encoder state, run tracking and flush request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            last_q       <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            last_q       <= last_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    rle_out_slot u_slot (
        .clock      (clock),
        .reset_n    (reset_n),
        .out_ready  (out_ready),
        .load_out   (load_out),
        .out_word   (out_word),
        .load_pend  (load_pend),
        .pend_word  (masked),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .pend_valid (pend_valid),
        .slot_free  (slot_free)
    );

endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: cycle table, directed corner sequences and randomized scoreboard for rle_encoder
module tb_rle_encoder;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        rle_en = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic        sel = 1'b0, ordy_dir = 1'b1, rnd_rdy = 1'b1, rnd_on = 1'b0, sb_on = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready, in_ready, out_valid, ir0, ir3, ov0, ov3;
    logic [31:0] out_data, od0, od3;
    logic [31:0] exp_q[$];
    int          n_chk = 0, n_pass = 0;

    typedef struct {
        logic        en, v;
        logic [31:0] d;
        logic        fl, rdy, e_ir, e_ov;
        logic [31:0] e_od;
    } vec_t;
    vec_t tbl[$];

    assign out_ready = rnd_on ? rnd_rdy : ordy_dir;
    assign in_ready  = sel ? ir3 : ir0;
    assign out_valid = sel ? ov3 : ov0;
    assign out_data  = sel ? od3 : od0;

    rle_encoder dut (
        .clock(clock), .reset_n(reset_n), .rle_en(rle_en),
        .in_data(in_data), .in_valid(in_valid && !sel), .in_ready(ir0),
        .flush(flush && !sel), .out_data(od0), .out_valid(ov0), .out_ready(out_ready)
    );

    rle_encoder #(.CW(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .rle_en(rle_en),
        .in_data(in_data), .in_valid(in_valid && sel), .in_ready(ir3),
        .flush(flush && sel), .out_data(od3), .out_valid(ov3), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        #1;
        rnd_rdy = $urandom_range(0, 9) < 7;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every word leaving the selected encoder must be the next one predicted
    always @(negedge clock) begin
        if (sb_on && reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_extra: got %h, expected no word", out_data);
            end else chk("sb_word", out_data, exp_q.pop_front());
        end
    end

    // Reference: split the segment into runs of equal low bits; each run yields its value,
    // then its repeat count chopped into saturated chunks plus a remainder.
    function automatic void model(input bit en, input logic [31:0] s[$], input int cw);
        longint mx = (longint'(1) << cw) - 1;
        longint r;
        int i = 0, j;
        if (!en) begin
            foreach (s[k]) exp_q.push_back(s[k]);
            return;
        end
        while (i < s.size()) begin
            j = i;
            while (j < s.size() && s[j][30:0] == s[i][30:0]) j++;
            exp_q.push_back({1'b0, s[i][30:0]});
            r = j - i - 1;
            while (r >= mx) begin
                exp_q.push_back({1'b1, 31'(mx)});
                r -= mx;
            end
            if (r > 0) exp_q.push_back({1'b1, 31'(r)});
            i = j;
        end
    endfunction

    task automatic send(input logic [31:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        do begin @(negedge clock); n++; end while (!in_ready && n < 200);
        if (!in_ready) begin n_chk++; $display("FAIL send_timeout: in_ready 0, expected 1"); end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        int n = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        do begin @(negedge clock); n++; end while (!in_ready && n < 200);
        if (!in_ready) begin n_chk++; $display("FAIL flush_timeout: in_ready 0, expected 1"); end
        tick();
    endtask

    function automatic vec_t row(input logic en, input logic v, input logic [31:0] d, input logic fl,
                                 input logic rdy, input logic e_ir, input logic e_ov, input logic [31:0] e_od);
        vec_t r;
        r = '{en, v, d, fl, rdy, e_ir, e_ov, e_od};
        return r;
    endfunction

    initial begin
        logic [31:0] vals[3];
        logic [31:0] smp[$];
        logic [31:0] cur;
        bit          en;
        int          n;
        vals = '{32'h1234_5678, 32'h0000_00A0, 32'h7FFF_FFFF};

        // en v d fl rdy | in_ready out_valid out_data
        tbl.push_back(row(0, 1, 32'h11, 0, 1, 1, 0, 32'h0));
        tbl.push_back(row(0, 1, 32'h22, 0, 1, 1, 1, 32'h11));
        tbl.push_back(row(0, 0, 32'h0,  0, 1, 1, 1, 32'h22));
        tbl.push_back(row(0, 0, 32'h0,  0, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 1, 32'h5,  0, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 1, 32'h5,  0, 1, 1, 1, 32'h5));
        tbl.push_back(row(1, 1, 32'h5,  0, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 1, 32'h5,  0, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 1, 32'h9,  0, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 0, 32'h0,  0, 1, 0, 1, 32'h8000_0003));
        tbl.push_back(row(1, 0, 32'h0,  1, 1, 1, 1, 32'h9));
        tbl.push_back(row(1, 0, 32'h0,  0, 1, 0, 0, 32'h0));
        tbl.push_back(row(1, 0, 32'h0,  0, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 1, 32'h7,  0, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 1, 32'h7,  0, 1, 1, 1, 32'h7));
        tbl.push_back(row(1, 0, 32'h0,  1, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 0, 32'h0,  0, 1, 0, 0, 32'h0));
        tbl.push_back(row(1, 1, 32'h7,  0, 1, 1, 1, 32'h8000_0001));
        tbl.push_back(row(1, 0, 32'h0,  0, 1, 1, 1, 32'h7));
        tbl.push_back(row(1, 0, 32'h0,  1, 1, 1, 0, 32'h0));
        tbl.push_back(row(1, 0, 32'h0,  0, 1, 0, 0, 32'h0));
        tbl.push_back(row(1, 0, 32'h0,  0, 1, 1, 0, 32'h0));

        repeat (3) @(posedge clock);
        chk("rst_ov3", 32'(ov3), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            rle_en = tbl[i].en; in_valid = tbl[i].v; in_data = tbl[i].d;
            flush = tbl[i].fl; ordy_dir = tbl[i].rdy;
            @(negedge clock);
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;

        // Output stall: marker bit stripped, word held, next sample waits
        rle_en = 1'b1; ordy_dir = 1'b0; in_valid = 1'b1; in_data = 32'h8000_0005;
        @(negedge clock);
        chk("stall_first_ready", 32'(in_ready), 32'd1);
        tick();
        in_data = 32'h6;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_out_data", c), out_data, 32'h5);
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            tick();
        end
        ordy_dir = 1'b1;
        @(negedge clock);
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("stall_next_valid", 32'(out_valid), 32'd1);
        chk("stall_next_data", out_data, 32'h6);
        tick();
        do_flush();

        // Reset mid-run with a count word in the slot and a value pending behind it
        in_valid = 1'b1; in_data = 32'h3;
        repeat (3) tick();
        in_data = 32'h5; ordy_dir = 1'b0;
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("prerst_out_valid", 32'(out_valid), 32'd1);
        chk("prerst_out_data", out_data, 32'h8000_0002);
        chk("prerst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #3 reset_n = 1'b1;
        tick();
        ordy_dir = 1'b1; in_valid = 1'b1; in_data = 32'h3;
        @(negedge clock);
        chk("postrst_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_data", out_data, 32'h3);
        tick();
        @(negedge clock);
        chk("postrst_no_extra", 32'(out_valid), 32'd0);
        tick();
        do_flush();

        // Counter saturation with a 3-bit run counter
        sel = 1'b1; sb_on = 1'b1; rle_en = 1'b1;
        exp_q = '{32'hA, 32'h8000_0007, 32'h8000_0001};
        repeat (9) send(32'hA);
        do_flush();
        chk("cw3_drain", 32'(exp_q.size()), 32'd0);

        // Randomized segments against the run-splitting reference
        rnd_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            for (int g = 0; g < 12; g++) begin
                en = 1'($urandom_range(0, 1));
                n = $urandom_range(1, 20);
                smp = {};
                cur = vals[0];
                for (int i = 0; i < n; i++) begin
                    if (i == 0 || $urandom_range(0, 7) == 0) cur = vals[$urandom_range(0, 2)];
                    smp.push_back(cur ^ ($urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'h0));
                end
                model(en, smp, k ? 3 : 31);
                rle_en = en;
                foreach (smp[i]) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(smp[i]);
                    if (en) rle_en = 1'($urandom_range(0, 1));
                end
                do_flush();
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);
        rnd_on = 1'b0; sb_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
